// File: rtl/gpio_pad_config_sequencer.sv
// Serial configuration controller for the user I/O pads: holds one mode word per pad
// and shifts the whole table out on a clock/data/load chain on command.
module gpio_pad_config_sequencer #(
  parameter int unsigned NUM_PADS     = 12,
  parameter int unsigned BITS_PER_PAD = 12,
  parameter int unsigned CLK_DIV      = 4,
  parameter logic [BITS_PER_PAD-1:0] RESET_MODE = 12'h006
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode_we,
  input  logic [3:0]              mode_addr,
  input  logic [BITS_PER_PAD-1:0] mode_wdata,
  output logic [BITS_PER_PAD-1:0] mode_rdata,
  output logic                    serial_clock,
  output logic                    serial_data,
  output logic                    serial_load,
  output logic                    busy,
  output logic                    done,
  output logic                    configured
);

  localparam int unsigned PAD_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
  localparam int unsigned BIT_W = (BITS_PER_PAD > 1) ? $clog2(BITS_PER_PAD) : 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'(NUM_PADS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_PAD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOAD,
    S_FINISH
  } state_t;

  state_t                  state_q, state_d;
  logic [PAD_W-1:0]        pad_q, pad_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [BITS_PER_PAD-1:0] mode_tbl [NUM_PADS];
  logic [BITS_PER_PAD-1:0] word_d;
  logic                    addr_ok;
  logic                    wr_ok;
  logic                    sclk_d, sdata_d, sload_d, busy_d, done_d;

  assign addr_ok    = 32'(mode_addr) < NUM_PADS;
  assign wr_ok      = mode_we && (state_q == S_IDLE) && addr_ok;
  assign mode_rdata = addr_ok ? mode_tbl[PAD_W'(mode_addr)] : '0;

  // Next state, counters and next registered output values
  always_comb begin
    state_d = state_q;
    pad_d   = pad_q;
    bit_d   = bit_q;
    div_d   = div_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          pad_d   = PAD_LAST;
          bit_d   = BIT_LAST;
          div_d   = DIV_LAST;
        end
      end
      S_SETUP: begin
        if (div_q == '0) begin
          state_d = S_HIGH;
          div_d   = DIV_LAST;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      S_HIGH: begin
        if (div_q == '0) begin
          div_d = DIV_LAST;
          if (pad_q == '0 && bit_q == '0) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_SETUP;
            if (bit_q == '0) begin
              bit_d = BIT_LAST;
              pad_d = pad_q - PAD_W'(1);
            end else begin
              bit_d = bit_q - BIT_W'(1);
            end
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      S_LOAD: begin
        if (div_q == '0) state_d = S_FINISH;
        else             div_d   = div_q - DIV_W'(1);
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // A write landing on the start edge must reach the first shifted bit
    word_d = mode_tbl[pad_d];
    if (wr_ok && PAD_W'(mode_addr) == pad_d) word_d = mode_wdata;

    sclk_d  = (state_d == S_HIGH);
    sload_d = (state_d == S_LOAD);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FINISH);
    sdata_d = (state_d == S_SETUP || state_d == S_HIGH) ? word_d[bit_d] : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pad_q        <= '0;
      bit_q        <= '0;
      div_q        <= '0;
      serial_clock <= 1'b0;
      serial_data  <= 1'b0;
      serial_load  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      configured   <= 1'b0;
      for (int unsigned i = 0; i < NUM_PADS; i++) mode_tbl[i] <= RESET_MODE;
    end else begin
      state_q      <= state_d;
      pad_q        <= pad_d;
      bit_q        <= bit_d;
      div_q        <= div_d;
      serial_clock <= sclk_d;
      serial_data  <= sdata_d;
      serial_load  <= sload_d;
      busy         <= busy_d;
      done         <= done_d;
      configured   <= configured | done_d;
      if (wr_ok) mode_tbl[PAD_W'(mode_addr)] <= mode_wdata;
    end
  end

endmodule

// File: doc/gpio_pad_config_sequencer.md
# gpio_pad_config_sequencer

Serial configuration controller for the 12 user I/O pads of the fabric top level. It holds one 12-bit GPIO mode word per pad, such as 12'h006 for bidirectional or 12'hB86 for force-one output, in a writable mode table. On command, it shifts the whole table out on a three-wire serial chain (clock, data, load) to the pad configuration shift registers. Completion is reported with a one-cycle `done` pulse and a sticky `configured` flag.

## Interface
- `NUM_PADS`, 12, number of pads in the chain (1..16).
- `BITS_PER_PAD`, 12, mode-word width per pad.
- `CLK_DIV`, 4, `clk` cycles per serial-clock half period (>=1).
- `RESET_MODE`, 12'h006, reset value of every table entry.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: begins a shift sequence when sampled high in IDLE.
- `mode_we` in 1: table write strobe.
- `mode_addr` in 4: table index for both write and read.
- `mode_wdata` in 12: table write data.
- `mode_rdata` out 12: combinational table read at `mode_addr`; 0 when `mode_addr` >= `NUM_PADS`.
- `serial_clock` out 1: chain shift clock.
- `serial_data` out 1: chain data, MSB of each word first.
- `serial_load` out 1: chain load strobe.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a sequence completes.
- `configured` out 1: sticky; set by `done`, cleared only by `reset`.

## Operation
- FSM states: IDLE, SETUP, HIGH, LOAD, FINISH.
- IDLE:
  - `start`=1 moves to SETUP, with pad index = `NUM_PADS`-1 and bit index = `BITS_PER_PAD`-1.
  - Otherwise the FSM stays in IDLE.
- SETUP:
  - `serial_clock`=0 and `serial_data` = table[pad][bit] for `CLK_DIV` cycles, then go to HIGH.
- HIGH:
  - `serial_clock`=1 for `CLK_DIV` cycles; `serial_data` is held.
  - The chain samples `serial_data` on the rising edge of `serial_clock`.
- Leaving HIGH:
  - If this was bit 0 of pad 0, go to LOAD.
  - Otherwise decrement the bit index. When the bit index wraps from 0, set it to `BITS_PER_PAD`-1 and decrement the pad index. Then go to SETUP.
- Shift order: pad `NUM_PADS`-1 first, pad 0 last, MSB first within each word.
- LOAD: `serial_clock`=0, `serial_data`=0, `serial_load`=1 for `CLK_DIV` cycles, then go to FINISH.
- FINISH: `done`=1 for one cycle, `configured` is set, then go to IDLE.
- Table writes:
  - Accepted only when `busy`=0 and `mode_addr` < `NUM_PADS`.
  - A write while busy or to an out-of-range address is dropped silently.
  - The table is never modified mid-sequence.
- `start` while busy is ignored; there is no queueing.
- Simultaneous `start` and `mode_we` in IDLE: the write takes effect, and the shift uses the updated table.
- `reset` asserted mid-operation:
  - All outputs drop to 0 immediately (asynchronously) and the FSM returns to IDLE.
  - The table returns to `RESET_MODE` and `configured` is cleared.
  - The partially shifted chain is not loaded.
- A divider counter of width clog2(`CLK_DIV`) counts `CLK_DIV`-1 down to 0 in each timed state.

## Timing
- Reset values:
  - `serial_clock`, `serial_data`, `serial_load`, `busy`, `done`, `configured` = 0.
  - FSM in IDLE; all table entries = `RESET_MODE`.
- All outputs except `mode_rdata` are registered.
- `start` is sampled at edge T0:
  - `busy`=1 and SETUP begin after T0.
  - The first rising edge of `serial_clock` occurs at T0+`CLK_DIV`.
- Each bit takes 2·`CLK_DIV` cycles.
- Total shift = `NUM_PADS`·`BITS_PER_PAD`·2·`CLK_DIV` cycles, which is 1152 at the defaults.
- `serial_load` is high during cycles [T0+S, T0+S+`CLK_DIV`), where S is the total shift length.
- `done` is high in cycle T0+S+`CLK_DIV`; `busy` deasserts the cycle after that.
- At the defaults: `done` at T0+1156, back in IDLE at T0+1157.
- A new `start` is accepted in the first IDLE cycle.

## Test plan
- Reset check: after `reset`, all outputs = 0, `mode_rdata` at addr 0..11 = 12'h006, and at addr 12..15 = 0.
- Default shift:
  - Stimulus: pulse `start` with the default table.
  - Required: exactly 144 `serial_clock` rising edges; every 12-bit group sampled = 000000000110.
  - Required: `serial_load` high for 4 cycles, `done` at T0+1156, `configured`=1 afterwards.
- Ordering:
  - Stimulus: write pad 0 = 12'hB86 and pad 11 = 12'h2C6, then start.
  - Required: the first 12 sampled bits = 001011000110; the last 12 = 101110000110.
- Busy protection:
  - Stimulus: during a shift, write pad 3 = 12'h4C1 and pulse `start` again.
  - Required: the stream is unchanged, only one `done` pulse occurs, and `mode_rdata`[3] = 12'h006 afterwards.
- Reset mid-shift:
  - Stimulus: assert `reset` after 50 serial bits.
  - Required: all outputs go to 0 the same cycle, no `serial_load` ever pulses, and `configured`=0.
  - Required: a subsequent `start` produces a full 144-bit sequence.
- Out-of-range and CLK_DIV=1:
  - Stimulus: write addr 13; separately, run a sequence with `CLK_DIV`=1.
  - Required: `mode_rdata` at addr 13 stays 0.
  - Required: with `CLK_DIV`=1, `serial_clock` toggles every cycle and `done` arrives at T0+289.
